store_buffer: RTL and testbench
===============================

# store_buffer

Four-entry FIFO write buffer between the execute/memory stage and the data memory. It accepts SW/SH/SB requests from the pipeline and retires them in order into the data memory's write port, one per cycle. Because the memory uses a single shared address port, a store only drains in a cycle when no load owns that port. Loads are checked against buffered stores: a full-word match is forwarded, and a partial-width match stalls the load.

## Interface
Parameters:
- DEPTH, 4, number of buffer entries; must be a power of two, ≥2.
- AW, 8, number of low byte-address bits compared for forwarding (matches the 64-word data memory).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- st_valid  in  1  store request from the pipeline.
- st_ready  out  1  buffer can accept a store this cycle; equals !full.
- st_type  in  2  store kind, same encoding as the memory's write control: 00 none, 01 SW, 10 SH, 11 SB.
- st_addr  in  32  store byte address.
- st_data  in  32  store data, raw rs2 value.
- ld_valid  in  1  a load is using the memory address port this cycle.
- ld_addr  in  32  load byte address.
- ld_hit  out  1  load is satisfied from the buffer; use ld_fwd_data, not memory.
- ld_fwd_data  out  32  full 32-bit data of the youngest matching SW entry. Sign or zero extension is done by the consumer.
- ld_stall  out  1  youngest matching entry is SH/SB; the load must hold.
- mem_write  out  2  write control to the data memory; 00 when idle.
- mem_addr  out  32  write address to the data memory.
- mem_wdata  out  32  write data to the data memory.
- empty  out  1  no valid entries.
- count  out  $clog2(DEPTH+1)  number of valid entries.

## Operation
- Storage: a circular FIFO with head and tail pointers (log2 DEPTH bits, wrapping naturally) and a count register. Each entry holds {type, addr, data}.
- Enqueue: on a clock edge with st_valid && st_ready && st_type != 00, write the entry at tail and increment tail.
  - st_type 00 with st_valid is ignored: no entry, no state change.
- Drain condition: drain = !empty && (!ld_valid || ld_stall).
  - While drain is 1, mem_write, mem_addr and mem_wdata present the head entry combinationally.
  - While drain is 0, mem_write=00, mem_addr=0, mem_wdata=0.
  - On the clock edge with drain=1, the memory performs the write and head increments (pop).
- Deadlock rule: ld_stall overrides ld_valid for draining. The consumer treats the memory read data as invalid while ld_stall=1.
- Forward match: word compare ld_addr[AW-1:2] == entry.addr[AW-1:2] over valid entries only. The youngest match (closest to tail) wins.
- Forward outputs are combinational, qualified by ld_valid:
  - Youngest match is SW: ld_hit=1, ld_fwd_data=entry.data, ld_stall=0.
  - Youngest match is SH or SB: ld_stall=1, ld_hit=0.
  - No match, or ld_valid=0: ld_hit=0, ld_stall=0, ld_fwd_data=0.
- A store being enqueued in the same cycle is not visible to forwarding. Forwarding sees registered entries only.
- count update:
  - +1 on enqueue only.
  - −1 on pop only.
  - Unchanged when both occur in the same cycle.
- Full case: st_ready=0 when count==DEPTH, even if a pop occurs that cycle. There is no same-cycle refill when full.
- Ordering: memory writes occur strictly in enqueue order. Addresses and types pass through unmodified.

## Timing
- Reset (rst=0), asynchronous and immediate:
  - head=0, tail=0, count=0, all entries invalid.
  - Outputs: empty=1, st_ready=1, mem_write=00, mem_addr=0, mem_wdata=0, ld_hit=0, ld_stall=0, ld_fwd_data=0.
- Reset mid-operation discards all buffered stores; none reach memory.
- Minimum store latency: a store accepted at edge N drains at edge N+1 if no load is present.
- Throughput: one enqueue and one pop per cycle.
- ld_stall deasserts on the cycle after the last matching SH/SB entry pops, unless an older-to-younger SW match remains, in which case ld_hit=1.
- Reset release is asynchronous; the first enqueue can occur at the first rising edge with rst=1.

## Test plan
- Reset mid-flight: two entries buffered, ld_valid=1, drive rst=0 between edges → empty=1, count=0, mem_write=00 with no clock edge; nothing is written after rst=1.
- Fill and order: hold ld_valid=1 with no match, enqueue SW to 0x00, 0x04, 0x08, 0x0C → count=4, st_ready=0; a 5th store is refused. Drop ld_valid → mem_addr 0x00, 0x04, 0x08, 0x0C on four consecutive edges with mem_write=01, then empty=1.
- Forward youngest: SW 0x10 data 0xDEADBEEF, then SW 0x10 data 0x12345678, then ld_valid with ld_addr=0x12 → ld_hit=1, ld_fwd_data=0x12345678, ld_stall=0.
- Partial stall: SB 0x20 data 0x000000AB, then ld_valid with ld_addr=0x20 → ld_stall=1 and mem_write=11 at 0x20 despite ld_valid. Next cycle ld_stall=0, ld_hit=0, empty=1.
- Simultaneous push and pop: count=2, no load, enqueue SW 0x30 → count stays 2, with head and tail each advancing. Repeat across a pointer wrap and confirm FIFO order is preserved.
- Null store: st_valid=1, st_type=00 → count unchanged, mem_write=00.

Source files
------------

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - store, load-forward and memory write port bundle for store_buffer
interface store_buffer_if #(
  parameter int DEPTH = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic          st_valid;
  logic          st_ready;
  logic [1:0]    st_type;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          ld_valid;
  logic [31:0]   ld_addr;
  logic          ld_hit;
  logic [31:0]   ld_fwd_data;
  logic          ld_stall;
  logic [1:0]    mem_write;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_type, st_addr, st_data, ld_valid, ld_addr,
    input  st_ready, ld_hit, ld_fwd_data, ld_stall,
    input  mem_write, mem_addr, mem_wdata, empty, count
  );

  modport slave (
    input  st_valid, st_type, st_addr, st_data, ld_valid, ld_addr,
    output st_ready, ld_hit, ld_fwd_data, ld_stall,
    output mem_write, mem_addr, mem_wdata, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - in-order store FIFO with load forwarding and load-priority draining
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  store_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [1:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        ent_d [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          full;
  logic          is_empty;
  logic          push;
  logic          pop;
  logic          match_any;
  logic [PW-1:0] match_idx;
  logic [PW-1:0] idx;
  logic          unused_ld_addr_bits;

  assign unused_ld_addr_bits = ^{bus.ld_addr[31:AW], bus.ld_addr[1:0]};

  assign full     = (count_q == CW'(DEPTH));
  assign is_empty = (count_q == '0);
  assign push     = bus.st_valid && !full && (bus.st_type != 2'b00);

  // Walk oldest to youngest so the last hit left standing is the youngest match.
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + PW'(k);
      if ((CW'(k) < count_q) &&
          (ent_q[idx].addr[AW-1:2] == bus.ld_addr[AW-1:2])) begin
        match_any = 1'b1;
        match_idx = idx;
      end
    end
  end

  always_comb begin
    bus.ld_hit      = 1'b0;
    bus.ld_stall    = 1'b0;
    bus.ld_fwd_data = '0;
    if (bus.ld_valid && match_any) begin
      if (ent_q[match_idx].typ == 2'b01) begin
        bus.ld_hit      = 1'b1;
        bus.ld_fwd_data = ent_q[match_idx].data;
      end else begin
        bus.ld_stall = 1'b1;
      end
    end
  end

  // A stalled load cannot use the port, so the buffer drains through it to break the wait.
  assign pop = !is_empty && (!bus.ld_valid || bus.ld_stall);

  always_comb begin
    bus.mem_write = 2'b00;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (pop) begin
      bus.mem_write = ent_q[head_q].typ;
      bus.mem_addr  = ent_q[head_q].addr;
      bus.mem_wdata = ent_q[head_q].data;
    end
  end

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      ent_d[tail_q] = '{typ: bus.st_type, addr: bus.st_addr, data: bus.st_data};
      tail_d        = tail_q + 1'b1;
    end
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ent_q   <= ent_d;
    end
  end

  assign bus.st_ready = !full;
  assign bus.empty    = is_empty;
  assign bus.count    = count_q;
endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - directed self-checking bench for store_buffer
module tb_store_buffer;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  store_buffer_if #(.DEPTH(4)) bus ();

  store_buffer #(.DEPTH(4), .AW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic v, input logic [1:0] t, input logic [31:0] a, input logic [31:0] d);
    bus.st_valid = v;
    bus.st_type  = t;
    bus.st_addr  = a;
    bus.st_data  = d;
  endtask

  task automatic set_load(input logic v, input logic [31:0] a);
    bus.ld_valid = v;
    bus.ld_addr  = a;
  endtask

  logic [31:0] push_addrs [5];
  logic [31:0] pop_addrs  [5];

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    set_store(1'b0, 2'b00, 32'h0, 32'h0);
    set_load(1'b0, 32'h0);
    #3;
    check("rst_empty",    32'(bus.empty),     32'd1);
    check("rst_ready",    32'(bus.st_ready),  32'd1);
    check("rst_count",    32'(bus.count),     32'd0);
    check("rst_memw",     32'(bus.mem_write), 32'd0);
    check("rst_memaddr",  bus.mem_addr,       32'h0);
    check("rst_memwdata", bus.mem_wdata,      32'h0);
    check("rst_hit",      32'(bus.ld_hit),    32'd0);
    check("rst_stall",    32'(bus.ld_stall),  32'd0);
    check("rst_fwd",      bus.ld_fwd_data,    32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Fill and order: a non-matching load holds the port while four SWs fill the buffer.
    set_load(1'b1, 32'h80);
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 2'b01, 32'(i * 4), 32'h1000 + 32'(i));
      tick();
    end
    check("fill_count", 32'(bus.count),     32'd4);
    check("fill_ready", 32'(bus.st_ready),  32'd0);
    check("fill_memw",  32'(bus.mem_write), 32'd0);
    set_store(1'b1, 2'b01, 32'h10, 32'h5555);
    tick();
    check("fill_refused", 32'(bus.count), 32'd4);
    set_store(1'b0, 2'b00, 32'h0, 32'h0);
    set_load(1'b0, 32'h0);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("order_memw",  32'(bus.mem_write), 32'd1);
      check("order_addr",  bus.mem_addr,       32'(i * 4));
      check("order_wdata", bus.mem_wdata,      32'h1000 + 32'(i));
      tick();
    end
    check("order_empty", 32'(bus.empty),     32'd1);
    check("order_count", 32'(bus.count),     32'd0);
    check("order_idle",  32'(bus.mem_write), 32'd0);

    // Forward youngest; a store entering this cycle is invisible to forwarding.
    set_load(1'b1, 32'h10);
    set_store(1'b1, 2'b01, 32'h10, 32'hDEADBEEF);
    #1;
    check("fwd_same_cycle_hit", 32'(bus.ld_hit), 32'd0);
    tick();
    set_store(1'b1, 2'b01, 32'h10, 32'h12345678);
    #1;
    check("fwd_first_hit",  32'(bus.ld_hit), 32'd1);
    check("fwd_first_data", bus.ld_fwd_data, 32'hDEADBEEF);
    tick();
    set_store(1'b0, 2'b00, 32'h0, 32'h0);
    set_load(1'b1, 32'h12);
    #1;
    check("fwd_hit",   32'(bus.ld_hit),    32'd1);
    check("fwd_data",  bus.ld_fwd_data,    32'h12345678);
    check("fwd_stall", 32'(bus.ld_stall),  32'd0);
    check("fwd_memw",  32'(bus.mem_write), 32'd0);
    set_load(1'b0, 32'h0);
    tick();
    tick();
    check("fwd_drained", 32'(bus.empty), 32'd1);

    // Partial stall: an SB match stalls the load and drains despite ld_valid.
    set_load(1'b1, 32'h80);
    set_store(1'b1, 2'b11, 32'h20, 32'h000000AB);
    tick();
    set_store(1'b0, 2'b00, 32'h0, 32'h0);
    set_load(1'b1, 32'h20);
    #1;
    check("stall_stall", 32'(bus.ld_stall),  32'd1);
    check("stall_hit",   32'(bus.ld_hit),    32'd0);
    check("stall_memw",  32'(bus.mem_write), 32'd3);
    check("stall_addr",  bus.mem_addr,       32'h20);
    check("stall_wdata", bus.mem_wdata,      32'h000000AB);
    tick();
    check("stall_clear", 32'(bus.ld_stall), 32'd0);
    check("stall_nohit", 32'(bus.ld_hit),   32'd0);
    check("stall_empty", 32'(bus.empty),    32'd1);

    // Younger SW over an older SB at the same word forwards instead of stalling.
    set_load(1'b1, 32'h80);
    set_store(1'b1, 2'b11, 32'h24, 32'h00000011);
    tick();
    set_store(1'b1, 2'b01, 32'h24, 32'hCAFEF00D);
    tick();
    set_store(1'b0, 2'b00, 32'h0, 32'h0);
    set_load(1'b1, 32'h26);
    #1;
    check("mix_hit",   32'(bus.ld_hit),   32'd1);
    check("mix_data",  bus.ld_fwd_data,   32'hCAFEF00D);
    check("mix_stall", 32'(bus.ld_stall), 32'd0);
    set_load(1'b0, 32'h0);
    tick();
    tick();
    check("mix_empty", 32'(bus.empty), 32'd1);

    // Simultaneous push and pop across a pointer wrap.
    set_load(1'b1, 32'h80);
    set_store(1'b1, 2'b01, 32'h40, 32'h40);
    tick();
    set_store(1'b1, 2'b01, 32'h44, 32'h44);
    tick();
    check("pp_count0", 32'(bus.count), 32'd2);
    set_load(1'b0, 32'h0);
    push_addrs = '{32'h30, 32'h34, 32'h38, 32'h3C, 32'h2C};
    pop_addrs  = '{32'h40, 32'h44, 32'h30, 32'h34, 32'h38};
    for (int i = 0; i < 5; i++) begin
      set_store(1'b1, 2'b01, push_addrs[i], push_addrs[i]);
      #1;
      check("pp_memw", 32'(bus.mem_write), 32'd1);
      check("pp_addr", bus.mem_addr,       pop_addrs[i]);
      tick();
      check("pp_count", 32'(bus.count), 32'd2);
    end
    set_store(1'b0, 2'b00, 32'h0, 32'h0);
    #1;
    check("pp_tail0", bus.mem_addr, 32'h3C);
    tick();
    check("pp_tail1", bus.mem_addr, 32'h2C);
    tick();
    check("pp_empty", 32'(bus.empty), 32'd1);

    // Null store changes nothing, empty or not.
    set_store(1'b1, 2'b00, 32'h50, 32'h50);
    tick();
    check("null_count_empty", 32'(bus.count),     32'd0);
    check("null_memw",        32'(bus.mem_write), 32'd0);
    set_load(1'b1, 32'h80);
    set_store(1'b1, 2'b10, 32'h54, 32'h54);
    tick();
    set_store(1'b1, 2'b00, 32'h58, 32'h58);
    tick();
    check("null_count_one", 32'(bus.count), 32'd1);
    set_store(1'b0, 2'b00, 32'h0, 32'h0);

    // Reset mid-flight: two more entries buffered, asynchronous reset between edges.
    set_store(1'b1, 2'b01, 32'h60, 32'h60);
    tick();
    set_store(1'b0, 2'b00, 32'h0, 32'h0);
    set_load(1'b1, 32'h60);
    #1;
    check("mid_count_pre", 32'(bus.count),  32'd2);
    check("mid_hit_pre",   32'(bus.ld_hit), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("mid_empty", 32'(bus.empty),     32'd1);
    check("mid_count", 32'(bus.count),     32'd0);
    check("mid_memw",  32'(bus.mem_write), 32'd0);
    check("mid_hit",   32'(bus.ld_hit),    32'd0);
    @(negedge clk);
    rst = 1'b1;
    set_load(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_rst_memw",  32'(bus.mem_write), 32'd0);
      check("post_rst_empty", 32'(bus.empty),     32'd1);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
